baccarat_dealer_fsm: RTL and testbench

//  Controller for the Baccarat datapath. Sequences the card-load strobes for the

---
 rtl/baccarat_pkg.sv | 33 +++
 rtl/banker_draw_rule.sv | 27 ++
 rtl/baccarat_dealer_fsm.sv | 117 +++++++++++
 tb/tb_baccarat_dealer_fsm.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// ----------------------------------------------------------------------------
// baccarat_pkg : shared state encoding, rule constants and card valuation
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

package baccarat_pkg;

    typedef enum logic [3:0] {
        S_RST   = 4'd0,
        DEAL_P1 = 4'd1,
        DEAL_D1 = 4'd2,
        DEAL_P2 = 4'd3,
        DEAL_D2 = 4'd4,
        EVAL    = 4'd5,
        DEAL_P3 = 4'd6,
        EVAL_B  = 4'd7,
        DEAL_D3 = 4'd8,
        RESULT  = 4'd9,
        DONE    = 4'd10
    } state_t;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;

    // Tens and face cards count as zero.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= 4'd10) ? 4'd0 : rank;
    endfunction

endpackage

`default_nettype wire

// File: rtl/banker_draw_rule.sv
// ----------------------------------------------------------------------------
// banker_draw_rule : banker third-card tableau, given banker total and player v
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module banker_draw_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] v,
    output logic       draw
);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/baccarat_dealer_fsm.sv
// ----------------------------------------------------------------------------
// baccarat_dealer_fsm : sequences card loads, applies baccarat drawing rules
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module baccarat_dealer_fsm
    import baccarat_pkg::*;
#(
    parameter int CARD_W  = 4,
    parameter int SCORE_W = 4
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               advance,
    input  logic [SCORE_W-1:0] pscore,
    input  logic [SCORE_W-1:0] dscore,
    input  logic [CARD_W-1:0]  pcard3,
    output logic               load_pcard1,
    output logic               load_pcard2,
    output logic               load_pcard3,
    output logic               load_dcard1,
    output logic               load_dcard2,
    output logic               load_dcard3,
    output logic               player_win_light,
    output logic               dealer_win_light,
    output logic               hand_done
);

    state_t state_q, state_d;
    logic   player_win_q, player_win_d;
    logic   dealer_win_q, dealer_win_d;
    logic   banker_draw;

    banker_draw_rule u_banker_draw_rule (
        .dscore (dscore),
        .v      (card_value(pcard3)),
        .draw   (banker_draw)
    );

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= S_RST;
            player_win_q <= 1'b0;
            dealer_win_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            player_win_q <= player_win_d;
            dealer_win_q <= dealer_win_d;
        end
    end

    // Strobes come straight from state_q, so an async reset drops them at once.
    always_comb begin
        state_d      = state_q;
        player_win_d = player_win_q;
        dealer_win_d = dealer_win_q;
        load_pcard1  = 1'b0;
        load_pcard2  = 1'b0;
        load_pcard3  = 1'b0;
        load_dcard1  = 1'b0;
        load_dcard2  = 1'b0;
        load_dcard3  = 1'b0;
        case (state_q)
            S_RST:   if (advance) state_d = DEAL_P1;
            DEAL_P1: begin
                load_pcard1 = advance;
                if (advance) state_d = DEAL_D1;
            end
            DEAL_D1: begin
                load_dcard1 = advance;
                if (advance) state_d = DEAL_P2;
            end
            DEAL_P2: begin
                load_pcard2 = advance;
                if (advance) state_d = DEAL_D2;
            end
            DEAL_D2: begin
                load_dcard2 = advance;
                if (advance) state_d = EVAL;
            end
            EVAL: if (advance) begin
                if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN)
                    state_d = RESULT;
                else if (pscore < PLAYER_STAND_MIN)
                    state_d = DEAL_P3;
                else if (dscore < PLAYER_STAND_MIN)
                    state_d = DEAL_D3;
                else
                    state_d = RESULT;
            end
            DEAL_P3: begin
                load_pcard3 = advance;
                if (advance) state_d = EVAL_B;
            end
            EVAL_B:  if (advance) state_d = banker_draw ? DEAL_D3 : RESULT;
            DEAL_D3: begin
                load_dcard3 = advance;
                if (advance) state_d = RESULT;
            end
            RESULT: if (advance) begin
                player_win_d = (pscore >= dscore);
                dealer_win_d = (dscore >= pscore);
                state_d      = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = S_RST;
        endcase
    end

    assign player_win_light = player_win_q;
    assign dealer_win_light = dealer_win_q;
    assign hand_done        = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_baccarat_dealer_fsm.sv
// ----------------------------------------------------------------------------
// tb_baccarat_dealer_fsm : directed hands with hand-computed strobes and lights
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_baccarat_dealer_fsm;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] P1   = 6'b100000;
    localparam logic [5:0] D1   = 6'b010000;
    localparam logic [5:0] P2   = 6'b001000;
    localparam logic [5:0] D2   = 6'b000100;
    localparam logic [5:0] P3   = 6'b000010;
    localparam logic [5:0] D3   = 6'b000001;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic       advance    = 1'b0;
    logic [3:0] pscore     = 4'd0;
    logic [3:0] dscore     = 4'd0;
    logic [3:0] pcard3     = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, hand_done;
    logic [5:0] strobes;
    logic [2:0] status;

    int checks = 0;
    int errors = 0;

    always #5 slow_clock = ~slow_clock;

    baccarat_dealer_fsm #(.CARD_W(4), .SCORE_W(4)) dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .advance          (advance),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .hand_done        (hand_done)
    );

    assign strobes = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3};
    assign status  = {player_win_light, dealer_win_light, hand_done};

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One advance pulse: strobe is sampled mid-cycle while advance is high.
    task automatic step(input string tag, input logic [5:0] exp);
        @(negedge slow_clock);
        advance = 1'b1;
        #1 check(tag, strobes, exp);
        @(posedge slow_clock);
        #1 advance = 1'b0;
    endtask

    task automatic new_hand();
        @(negedge slow_clock);
        resetb = 1'b0;
        @(negedge slow_clock);
        check("reset_status", {3'b000, status}, 6'b000000);
        resetb = 1'b1;
        step("rst_exit", NONE);
        step("deal_p1", P1);
        step("deal_d1", D1);
        step("deal_p2", P2);
        step("deal_d2", D2);
    endtask

    task automatic expect_status(input string tag, input logic [2:0] exp);
        @(negedge slow_clock);
        check(tag, {3'b000, status}, {3'b000, exp});
    endtask

    initial begin
        // 1: reset, deal, then idle
        repeat (3) @(negedge slow_clock);
        check("reset_strobes", strobes, NONE);
        check("reset_status0", {3'b000, status}, 6'b000000);
        resetb = 1'b1;
        step("rst_exit", NONE);
        step("deal_p1", P1);
        step("deal_d1", D1);
        step("deal_p2", P2);
        step("deal_d2", D2);
        for (int i = 0; i < 10; i++) begin
            @(negedge slow_clock);
            check("idle_strobes", strobes, NONE);
        end
        expect_status("idle_status", 3'b000);

        // 2: player natural
        pscore = 4'd8; dscore = 4'd3;
        step("nat_eval", NONE);
        expect_status("nat_result_not_done", 3'b000);
        step("nat_result", NONE);
        expect_status("nat_lights", 3'b101);

        // 3: both draw, banker wins
        new_hand();
        pscore = 4'd4; dscore = 4'd5; pcard3 = 4'd6;
        step("both_eval", NONE);
        step("both_p3", P3);
        step("both_evalb", NONE);
        step("both_d3", D3);
        pscore = 4'd2; dscore = 4'd9;
        step("both_result", NONE);
        expect_status("both_lights", 3'b011);

        // 4: banker on 6 stands against face-card third card
        new_hand();
        pscore = 4'd3; dscore = 4'd6; pcard3 = 4'd13;
        step("face_eval", NONE);
        step("face_p3", P3);
        step("face_evalb", NONE);
        step("face_result", NONE);
        expect_status("face_lights", 3'b011);

        // 5: player stands on 7, banker draws on 5, tie; DONE absorbs advance
        new_hand();
        pscore = 4'd7; dscore = 4'd5;
        step("tie_eval", NONE);
        step("tie_d3", D3);
        dscore = 4'd7;
        step("tie_result", NONE);
        expect_status("tie_lights", 3'b111);
        dscore = 4'd2;
        step("done_adv1", NONE);
        step("done_adv2", NONE);
        expect_status("done_hold", 3'b111);

        // 7: banker 3 stands on an 8 third card
        new_hand();
        pscore = 4'd0; dscore = 4'd3; pcard3 = 4'd8;
        step("b3v8_eval", NONE);
        step("b3v8_p3", P3);
        step("b3v8_evalb", NONE);
        step("b3v8_result", NONE);
        expect_status("b3v8_lights", 3'b011);

        // 8: both stand on 6, tie without any third card
        new_hand();
        pscore = 4'd6; dscore = 4'd6;
        step("stand66_eval", NONE);
        step("stand66_result", NONE);
        expect_status("stand66_lights", 3'b111);

        // 6: reset while load_pcard3 is high
        new_hand();
        pscore = 4'd4; dscore = 4'd5; pcard3 = 4'd2;
        step("mid_eval", NONE);
        @(negedge slow_clock);
        advance = 1'b1;
        #1 check("mid_p3_before", strobes, P3);
        #1 resetb = 1'b0;
        #1 check("mid_p3_dropped", strobes, NONE);
        check("mid_status", {3'b000, status}, 6'b000000);
        advance = 1'b0;
        @(negedge slow_clock);
        resetb = 1'b1;
        step("mid_rst_exit", NONE);
        step("mid_restart_p1", P1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
